vend_ctrl_p: RTL and testbench

VEND_CTRL_P -- requirements
Module: vend_ctrl_p

---
 rtl/vend_ctrl_p.sv | 173 +++++++++++++++++
 tb/tb_vend_ctrl_p.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vend_ctrl_p                                                  |
// | Description : Coin-operated vending controller. Credits coins, vends a     |
// |               selected product, returns change greedily in 10/5 rs coins,  |
// |               and tracks per-product stock with restock and sold-out flags.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vend_ctrl_p #(
  parameter int N_PROD     = 4,
  parameter int PRICE_STEP = 1,
  parameter int BAL_W      = 6,
  parameter int MAX_BAL    = 20,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8,
  localparam int SEL_W     = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        coin,
  input  logic              sel_valid,
  input  logic [SEL_W-1:0]  sel,
  input  logic              cancel,
  input  logic              restock,
  output logic              dispense,
  output logic [SEL_W-1:0]  disp_id,
  output logic              chg_valid,
  output logic [1:0]        chg_coin,
  output logic [BAL_W-1:0]  balance,
  output logic              busy,
  output logic              coin_reject,
  output logic              sel_err,
  output logic [N_PROD-1:0] sold_out
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_VEND    = 2'd1,
    S_CHANGE  = 2'd2
  } state_t;

  localparam logic [BAL_W:0]   MAX_SUM    = (BAL_W+1)'(MAX_BAL);
  localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_INIT);

  state_t             state;
  logic [STOCK_W-1:0] stock [N_PROD];

  logic [2:0]       coin_units;
  logic [BAL_W:0]   coin_sum;
  logic             coin_fits;
  logic             sel_in_range;
  logic             sel_ok;
  logic [BAL_W-1:0] sel_price;
  logic [BAL_W-1:0] vend_price;
  logic [BAL_W-1:0] vend_left;
  logic [BAL_W-1:0] chg_units;
  logic [BAL_W-1:0] chg_left;

  // Price of product id is (id+1) price steps.
  function automatic logic [BAL_W-1:0] price_of(input logic [SEL_W-1:0] id);
    return BAL_W'((int'(id) + 1) * PRICE_STEP);
  endfunction

  // Coin valuation, selection acceptance and balance arithmetic for this cycle.
  always_comb begin
    case (coin)
      2'b01:   coin_units = 3'd1;
      2'b10:   coin_units = 3'd2;
      2'b11:   coin_units = 3'd4;
      default: coin_units = 3'd0;
    endcase
    coin_sum     = {1'b0, balance} + (BAL_W+1)'(coin_units);
    coin_fits    = (coin_sum <= MAX_SUM);
    sel_in_range = (int'(sel) < N_PROD);
    sel_price    = price_of(sel);
    sel_ok       = sel_in_range && (stock[sel] != '0) && (balance >= sel_price);
    vend_price   = price_of(disp_id);
    vend_left    = balance - vend_price;
    // Greedy change: a 10 rs coin whenever two units remain, else a 5 rs coin.
    chg_units    = (balance >= BAL_W'(2)) ? BAL_W'(2) : BAL_W'(1);
    chg_left     = balance - chg_units;
  end

  // Transaction FSM with registered pulse outputs and balance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_COLLECT;
      balance     <= '0;
      disp_id     <= '0;
      dispense    <= 1'b0;
      chg_valid   <= 1'b0;
      chg_coin    <= 2'b00;
      busy        <= 1'b0;
      coin_reject <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      dispense    <= 1'b0;
      chg_valid   <= 1'b0;
      coin_reject <= 1'b0;
      sel_err     <= 1'b0;
      case (state)
        S_COLLECT: begin
          if (cancel && (balance != '0)) begin
            // Cancel wins; a same-cycle coin is handed back.
            state       <= S_CHANGE;
            busy        <= 1'b1;
            coin_reject <= (coin != 2'b00);
          end else if (sel_valid && sel_ok) begin
            // Dispense pulse covers the single VEND cycle.
            state       <= S_VEND;
            busy        <= 1'b1;
            disp_id     <= sel;
            dispense    <= 1'b1;
            coin_reject <= (coin != 2'b00);
          end else begin
            sel_err <= sel_valid;
            if (coin != 2'b00) begin
              if (coin_fits) balance <= coin_sum[BAL_W-1:0];
              else           coin_reject <= 1'b1;
            end
          end
        end
        S_VEND: begin
          coin_reject <= (coin != 2'b00);
          balance     <= vend_left;
          if (vend_left != '0) begin
            state <= S_CHANGE;
          end else begin
            state <= S_COLLECT;
            busy  <= 1'b0;
          end
        end
        S_CHANGE: begin
          coin_reject <= (coin != 2'b00);
          chg_valid   <= 1'b1;
          chg_coin    <= (chg_units == BAL_W'(2)) ? 2'b10 : 2'b01;
          balance     <= chg_left;
          if (chg_left == '0) begin
            state <= S_COLLECT;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_COLLECT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stock counters: decrement at the end of VEND, restock overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PROD; i++) stock[i] <= STOCK_FULL;
    end else begin
      for (int i = 0; i < N_PROD; i++) begin
        if (restock) begin
          stock[i] <= STOCK_FULL;
        end else if ((state == S_VEND) && (int'(disp_id) == i) && (stock[i] != '0)) begin
          stock[i] <= stock[i] - STOCK_W'(1);
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < N_PROD; g++) begin : g_sold
      assign sold_out[g] = (stock[g] == '0);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vend_ctrl_p                                               |
// | Description : Self-checking bench for vend_ctrl_p: directed scenarios with |
// |               literal expectations plus randomized traffic against a       |
// |               transaction-level reference model.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_vend_ctrl_p;

  localparam int N_PROD     = 4;
  localparam int PRICE_STEP = 1;
  localparam int BAL_W      = 6;
  localparam int MAX_BAL    = 20;
  localparam int STOCK_W    = 4;
  localparam int STOCK_INIT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       cancel = 1'b0;
  logic       restock = 1'b0;
  logic       dispense;
  logic [1:0] disp_id;
  logic       chg_valid;
  logic [1:0] chg_coin;
  logic [BAL_W-1:0] balance;
  logic       busy;
  logic       coin_reject;
  logic       sel_err;
  logic [N_PROD-1:0] sold_out;

  int errors = 0;
  int checks = 0;

  vend_ctrl_p #(
    .N_PROD(N_PROD), .PRICE_STEP(PRICE_STEP), .BAL_W(BAL_W), .MAX_BAL(MAX_BAL),
    .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .coin(coin), .sel_valid(sel_valid), .sel(sel),
    .cancel(cancel), .restock(restock), .dispense(dispense), .disp_id(disp_id),
    .chg_valid(chg_valid), .chg_coin(chg_coin), .balance(balance), .busy(busy),
    .coin_reject(coin_reject), .sel_err(sel_err), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One entry per future cycle of a transaction: what the outputs must show.
  typedef struct {
    int bal;
    int busy;
    int disp;
    int id;
    int chgv;
    int coin;
    int dec;
  } ent_t;

  ent_t plan[$];
  ent_t cur;
  int   m_bal = 0;
  int   m_stock[N_PROD];
  int   exp_rej = 0;
  int   exp_serr = 0;

  function automatic ent_t mk(int b, int bz, int d, int id, int cv, int cn, int dc);
    ent_t e;
    e.bal = b; e.busy = bz; e.disp = d; e.id = id; e.chgv = cv; e.coin = cn; e.dec = dc;
    return e;
  endfunction

  // Lay out the whole transaction timeline: optional vend, then greedy change.
  task automatic build(input int b0, input int is_vend, input int id);
    int b;
    int run;
    int coins[$];
    if (is_vend != 0) begin
      plan.push_back(mk(b0, 1, 1, id, 0, 0, -1));
      b = b0 - (id + 1) * PRICE_STEP;
    end else begin
      b = b0;
    end
    for (int k = 0; k < b / 2; k++) coins.push_back(2);
    if (b % 2 == 1) coins.push_back(1);
    run = b;
    for (int j = 0; j < coins.size(); j++) begin
      plan.push_back(mk(run, 1, 0, 0, (j > 0) ? 1 : 0, (j > 0) ? coins[j-1] : 0,
                        (j == 0 && is_vend != 0) ? id : -1));
      run -= coins[j];
    end
    if (coins.size() > 0)
      plan.push_back(mk(0, 0, 0, 0, 1, coins[coins.size()-1], -1));
    else
      plan.push_back(mk(0, 0, 0, 0, 0, 0, (is_vend != 0) ? id : -1));
  endtask

  function automatic int coin_value(input logic [1:0] c);
    case (c)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      plan.delete();
      m_bal = 0;
      for (int i = 0; i < N_PROD; i++) m_stock[i] = STOCK_INIT;
      cur = mk(0, 0, 0, 0, 0, 0, -1);
      exp_rej = 0;
      exp_serr = 0;
    end else begin
      exp_rej = 0;
      exp_serr = 0;
      if (plan.size() > 0) begin
        exp_rej = (coin != 2'b00) ? 1 : 0;
        cur = plan.pop_front();
      end else if (cancel && m_bal > 0) begin
        build(m_bal, 0, 0);
        cur = plan.pop_front();
        exp_rej = (coin != 2'b00) ? 1 : 0;
      end else if (sel_valid && int'(sel) < N_PROD && m_stock[sel] > 0 &&
                   m_bal >= (int'(sel) + 1) * PRICE_STEP) begin
        build(m_bal, 1, int'(sel));
        cur = plan.pop_front();
        exp_rej = (coin != 2'b00) ? 1 : 0;
      end else begin
        exp_serr = sel_valid ? 1 : 0;
        if (coin != 2'b00) begin
          if (m_bal + coin_value(coin) <= MAX_BAL) m_bal += coin_value(coin);
          else exp_rej = 1;
        end
        cur = mk(m_bal, 0, 0, 0, 0, 0, -1);
      end
      m_bal = cur.bal;
      if (cur.dec >= 0 && m_stock[cur.dec] > 0) m_stock[cur.dec]--;
      if (restock) for (int i = 0; i < N_PROD; i++) m_stock[i] = STOCK_INIT;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int so;
    so = 0;
    for (int i = 0; i < N_PROD; i++) if (m_stock[i] == 0) so |= (1 << i);
    chk("balance", int'(balance), cur.bal);
    chk("busy", int'(busy), cur.busy);
    chk("dispense", int'(dispense), cur.disp);
    if (cur.disp != 0) chk("disp_id", int'(disp_id), cur.id);
    chk("chg_valid", int'(chg_valid), cur.chgv);
    if (cur.chgv != 0) chk("chg_coin", int'(chg_coin), cur.coin);
    chk("coin_reject", int'(coin_reject), exp_rej);
    chk("sel_err", int'(sel_err), exp_serr);
    chk("sold_out", int'(sold_out), so);
  end

  // ---------------- stimulus ----------------
  // Drive one cycle of inputs; returns just after the edge that consumes them.
  task automatic step(input int c, input int sv, input int s, input int ca, input int rs);
    @(negedge clk);
    #2;
    coin = 2'(c); sel_valid = (sv != 0); sel = 2'(s); cancel = (ca != 0); restock = (rs != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    coin = 2'b00; sel_valid = 1'b0; cancel = 1'b0; restock = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_balance", int'(balance), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_chg_valid", int'(chg_valid), 0);
    chk("rst_dispense", int'(dispense), 0);
    chk("rst_sold_out", int'(sold_out), 0);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int tens;
    int pulses;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    chk("init_balance", int'(balance), 0);
    chk("init_sold_out", int'(sold_out), 0);

    // 10 rs + 5 rs, buy id 2 at 3 units: exact payment, no change.
    step(2, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("t1_balance3", int'(balance), 3);
    step(0, 1, 2, 0, 0);
    chk("t1_dispense", int'(dispense), 1);
    chk("t1_disp_id", int'(disp_id), 2);
    step(0, 0, 0, 0, 0);
    chk("t1_balance0", int'(balance), 0);
    chk("t1_no_chg", int'(chg_valid), 0);
    chk("t1_dispense_done", int'(dispense), 0);

    // 20 rs, buy id 0: change of 10 rs then 5 rs.
    step(3, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("t2_dispense", int'(dispense), 1);
    chk("t2_busy1", int'(busy), 1);
    step(0, 0, 0, 0, 0);
    chk("t2_busy2", int'(busy), 1);
    step(0, 0, 0, 0, 0);
    chk("t2_chg10", int'(chg_coin), 2);
    chk("t2_busy3", int'(busy), 1);
    step(0, 0, 0, 0, 0);
    chk("t2_chg5", int'(chg_coin), 1);
    chk("t2_chg5_valid", int'(chg_valid), 1);
    chk("t2_idle", int'(busy), 0);
    chk("t2_balance0", int'(balance), 0);

    // Balance 18, an overflowing 20 rs coin, then cancel: nine 10 rs coins.
    repeat (4) step(3, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0);
    chk("t3_balance18", int'(balance), 18);
    step(3, 0, 0, 0, 0);
    chk("t3_reject", int'(coin_reject), 1);
    chk("t3_balance_kept", int'(balance), 18);
    step(0, 0, 0, 1, 0);
    tens = 0;
    pulses = 0;
    for (int k = 0; k < 9; k++) begin
      step(0, 0, 0, 0, 0);
      if (chg_valid) pulses++;
      if (chg_valid && chg_coin == 2'b10) tens++;
    end
    chk("t3_pulses", pulses, 9);
    chk("t3_tens", tens, 9);
    chk("t3_back_to_collect", int'(busy), 0);

    // Drain product 3, then a refused selection, then restock.
    for (int k = 0; k < STOCK_INIT; k++) begin
      step(3, 0, 0, 0, 0);
      step(0, 1, 3, 0, 0);
      step(0, 0, 0, 0, 0);
    end
    chk("t4_sold_out3", int'(sold_out[3]), 1);
    step(3, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0);
    chk("t4_sel_err", int'(sel_err), 1);
    chk("t4_no_dispense", int'(dispense), 0);
    step(0, 0, 0, 0, 1);
    chk("t4_restocked", int'(sold_out[3]), 0);
    step(0, 0, 0, 1, 0);
    idle(3);

    // Cancel, selection and coin together with balance 2.
    step(2, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    chk("t5_busy", int'(busy), 1);
    chk("t5_reject", int'(coin_reject), 1);
    chk("t5_no_dispense", int'(dispense), 0);
    step(0, 0, 0, 0, 0);
    chk("t5_chg", int'(chg_valid), 1);
    chk("t5_balance0", int'(balance), 0);

    // Reset in the middle of returning change.
    step(2, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("t6_in_change", int'(busy), 1);
    do_reset();
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0);
      if (chg_valid) pulses++;
    end
    chk("t6_no_more_chg", pulses, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 9) < 4) ? int'($urandom_range(1, 3)) : 0,
             ($urandom_range(0, 3) == 0) ? 1 : 0,
             int'($urandom_range(0, N_PROD - 1)),
             ($urandom_range(0, 24) == 0) ? 1 : 0,
             ($urandom_range(0, 39) == 0) ? 1 : 0);
      end
    end
    idle(2);

    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
